// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: latch controls, FSM states and scoreboard entries.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_NOP    = 2'd0,
        PIPE_ENABLE = 2'd1,
        PIPE_STALL  = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } hazard_state_t;

    // wsel is stored at a fixed width wide enough for any supported REG_W (<= 8).
    localparam int SB_WSEL_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 is_load;
        logic [SB_WSEL_W-1:0] wsel;
    } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int FSEL_W = $clog2(NUM_FWD + 1);

    logic              ihit, dhit, dREN, dWEN;
    logic              issue, dec_wen, dec_is_load;
    logic [REG_W-1:0]  dec_rs, dec_rt, dec_wsel;
    logic [REG_W-1:0]  ex_rs, ex_rt;
    logic              branch_taken, jump;
    pipe_state_t       fd_state, de_state, em_state, mw_state;
    logic              pc_wen;
    logic [FSEL_W-1:0] fsel_a, fsel_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output ihit, dhit, dREN, dWEN, issue, dec_rs, dec_rt, dec_wsel, dec_wen,
               dec_is_load, ex_rs, ex_rt, branch_taken, jump,
        input  fd_state, de_state, em_state, mw_state, pc_wen, fsel_a, fsel_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dREN, dWEN, issue, dec_rs, dec_rt, dec_wsel, dec_wen,
               dec_is_load, ex_rs, ex_rt, branch_taken, jump,
        output fd_state, de_state, em_state, mw_state, pc_wen, fsel_a, fsel_b,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard s[0]=EX .. s[NUM_FWD], plus nearest-stage forward selection.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  pipe_state_t       de_state_i,
    input  pipe_state_t       em_state_i,
    input  logic              issue_i,
    input  logic              dec_wen_i,
    input  logic              dec_is_load_i,
    input  logic [REG_W-1:0]  dec_wsel_i,
    input  logic [REG_W-1:0]  ex_rs_i,
    input  logic [REG_W-1:0]  ex_rt_i,
    output sb_entry_t         s0_o,
    output logic [FSEL_W-1:0] fsel_a_o,
    output logic [FSEL_W-1:0] fsel_b_o
);

    sb_entry_t sb_q [NUM_FWD+1];
    sb_entry_t dec_entry;

    always_comb begin
        dec_entry         = '0;
        dec_entry.valid   = issue_i & dec_wen_i & (dec_wsel_i != '0);
        dec_entry.is_load = dec_is_load_i;
        dec_entry.wsel    = SB_WSEL_W'(dec_wsel_i);
    end

    // Only the valid bits are reset; wsel/is_load are meaningless while invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_FWD; k++) sb_q[k].valid <= 1'b0;
        end else begin
            case (de_state_i)
                PIPE_ENABLE: sb_q[0]       <= dec_entry;
                PIPE_NOP:    sb_q[0].valid <= 1'b0;
                default:     ;
            endcase
            if (em_state_i != PIPE_STALL) begin
                for (int k = 1; k <= NUM_FWD; k++) sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // Scan oldest to youngest so the nearest matching stage overwrites the result.
    function automatic logic [FSEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [FSEL_W-1:0] sel;
        sel = '0;
        if (src != '0) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (sb_q[k].valid && sb_q[k].wsel == SB_WSEL_W'(src)) sel = FSEL_W'(k);
            end
        end
        return sel;
    endfunction

    always_comb begin
        s0_o     = sb_q[0];
        fsel_a_o = fwd_sel(ex_rs_i);
        fsel_b_o = fwd_sel(ex_rt_i);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, data-memory wait and flush sequencing with perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int FSEL_W = $clog2(NUM_FWD + 1);

    hazard_state_t     state_q, state_d;
    pipe_state_t       fd_st, de_st, em_st, mw_st;
    logic              pc_wen, stall_inc, flush_inc;
    logic              mem_wait, redirect, load_use;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [FSEL_W-1:0] fsel_a, fsel_b;
    sb_entry_t         s0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != '1)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    hazard_scoreboard #(.REG_W(REG_W), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)) u_sb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .de_state_i    (de_st),
        .em_state_i    (em_st),
        .issue_i       (hz.issue),
        .dec_wen_i     (hz.dec_wen),
        .dec_is_load_i (hz.dec_is_load),
        .dec_wsel_i    (hz.dec_wsel),
        .ex_rs_i       (hz.ex_rs),
        .ex_rt_i       (hz.ex_rt),
        .s0_o          (s0),
        .fsel_a_o      (fsel_a),
        .fsel_b_o      (fsel_b)
    );

    always_comb begin
        mem_wait = (hz.dREN | hz.dWEN) & ~hz.dhit;
        redirect = hz.branch_taken | hz.jump;
        load_use = s0.valid & s0.is_load & (s0.wsel != '0) & hz.issue &
                   ((s0.wsel == SB_WSEL_W'(hz.dec_rs)) | (s0.wsel == SB_WSEL_W'(hz.dec_rt)));
    end

    always_comb begin
        state_d   = state_q;
        fd_st     = PIPE_ENABLE;
        de_st     = PIPE_ENABLE;
        em_st     = PIPE_ENABLE;
        mw_st     = PIPE_ENABLE;
        pc_wen    = 1'b1;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                if (!hz.dhit) begin
                    {fd_st, de_st, em_st, mw_st} = {4{PIPE_STALL}};
                    pc_wen    = 1'b0;
                    stall_inc = 1'b1;
                end else begin
                    // Exit cycle ignores ihit; the pending fetch is taken in RUN.
                    state_d = RUN;
                    pc_wen  = 1'b0;
                end
            end
            FLUSH: begin
                if (mem_wait) begin
                    state_d   = MEM_WAIT;
                    {fd_st, de_st, em_st, mw_st} = {4{PIPE_STALL}};
                    pc_wen    = 1'b0;
                    stall_inc = 1'b1;
                end else if (!hz.ihit) begin
                    fd_st  = PIPE_NOP;
                    de_st  = PIPE_NOP;
                    pc_wen = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                if (mem_wait) begin
                    state_d   = MEM_WAIT;
                    {fd_st, de_st, em_st, mw_st} = {4{PIPE_STALL}};
                    pc_wen    = 1'b0;
                    stall_inc = 1'b1;
                end else if (redirect) begin
                    state_d   = FLUSH;
                    fd_st     = PIPE_NOP;
                    de_st     = PIPE_NOP;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    state_d   = LD_STALL;
                    fd_st     = PIPE_STALL;
                    de_st     = PIPE_NOP;
                    pc_wen    = 1'b0;
                    stall_inc = 1'b1;
                end else if (!hz.ihit) begin
                    fd_st  = PIPE_STALL;
                    de_st  = PIPE_NOP;
                    pc_wen = 1'b0;
                end
            end
        endcase
        if (rst_i) begin
            {fd_st, de_st, em_st, mw_st} = {4{PIPE_NOP}};
            pc_wen    = 1'b0;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_inc);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_inc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.fd_state  = fd_st;
    assign hz.de_state  = de_st;
    assign hz.em_state  = em_st;
    assign hz.mw_state  = mw_st;
    assign hz.pc_wen    = pc_wen;
    assign hz.fsel_a    = fsel_a;
    assign hz.fsel_b    = fsel_b;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with CNT_W=2 shares the stimulus.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Latch-state words {fd,de,em,mw}: NOP=00, ENABLE=01, STALL=10
    localparam logic [7:0] ST_NOP   = 8'h00;
    localparam logic [7:0] ST_EN    = 8'h55;
    localparam logic [7:0] ST_STALL = 8'hAA;
    localparam logic [7:0] ST_LDB   = 8'h85;
    localparam logic [7:0] ST_FLB   = 8'h05;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    pipeline_hazard_ctrl_if #(.REG_W(5), .NUM_FWD(2), .CNT_W(16)) bus  ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .NUM_FWD(2), .CNT_W(2))  bus2 ();

    pipeline_hazard_ctrl #(.REG_W(5), .NUM_FWD(2), .CNT_W(16)) dut (
        .clk_i (clk), .rst_i (rst), .hz (bus)
    );
    pipeline_hazard_ctrl #(.REG_W(5), .NUM_FWD(2), .CNT_W(2)) dut_sat (
        .clk_i (clk), .rst_i (rst), .hz (bus2)
    );

    assign bus2.ihit         = bus.ihit;
    assign bus2.dhit         = bus.dhit;
    assign bus2.dREN         = bus.dREN;
    assign bus2.dWEN         = bus.dWEN;
    assign bus2.issue        = bus.issue;
    assign bus2.dec_rs       = bus.dec_rs;
    assign bus2.dec_rt       = bus.dec_rt;
    assign bus2.dec_wsel     = bus.dec_wsel;
    assign bus2.dec_wen      = bus.dec_wen;
    assign bus2.dec_is_load  = bus.dec_is_load;
    assign bus2.ex_rs        = bus.ex_rs;
    assign bus2.ex_rt        = bus.ex_rt;
    assign bus2.branch_taken = bus.branch_taken;
    assign bus2.jump         = bus.jump;

    logic [7:0] st;
    assign st = {bus.fd_state, bus.de_state, bus.em_state, bus.mw_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.issue = 1'b0; bus.dec_rs = '0; bus.dec_rt = '0; bus.dec_wsel = '0;
        bus.dec_wen = 1'b0; bus.dec_is_load = 1'b0; bus.ex_rs = '0; bus.ex_rt = '0;
        bus.branch_taken = 1'b0; bus.jump = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wsel, input logic ld);
        bus.issue = 1'b1; bus.dec_wen = 1'b1; bus.dec_rs = rs; bus.dec_rt = rt;
        bus.dec_wsel = wsel; bus.dec_is_load = ld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk); #1;
        n_chk++; if (st !== ST_NOP) $display("FAIL rst_states: got %h want %h", st, ST_NOP); else n_pass++;
        n_chk++; if (bus.pc_wen !== 1'b0 || bus.fsel_a !== 2'd0 || bus.fsel_b !== 2'd0)
            $display("FAIL rst_pcwen_fsel: got %b/%0d/%0d want 0/0/0", bus.pc_wen, bus.fsel_a, bus.fsel_b); else n_pass++;
        @(negedge clk); rst = 1'b0;
        bus.dREN = 1'b1; bus.dhit = 1'b0;
        @(negedge clk); #1;
        n_chk++; if (bus.stall_cnt !== 16'd1) $display("FAIL rst_pre_stallcnt: got %0d want 1", bus.stall_cnt); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if (st !== ST_NOP) $display("FAIL rst_mid_wait_states: got %h want %h", st, ST_NOP); else n_pass++;
        n_chk++; if (bus.stall_cnt !== 16'd0 || bus.pc_wen !== 1'b0)
            $display("FAIL rst_mid_wait_cnt: got %0d/%b want 0/0", bus.stall_cnt, bus.pc_wen); else n_pass++;
        @(negedge clk); rst = 1'b0; bus.dREN = 1'b0; #1;
        n_chk++; if (st !== ST_EN || bus.pc_wen !== 1'b1)
            $display("FAIL rst_release_run: got %h/%b want %h/1", st, bus.pc_wen, ST_EN); else n_pass++;
        n_chk++; if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0)
            $display("FAIL rst_release_cnts: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        decode(5'd0, 5'd0, 5'd2, 1'b1); #1;
        n_chk++; if (st !== ST_EN) $display("FAIL lu_load_issue: got %h want %h", st, ST_EN); else n_pass++;
        @(negedge clk); decode(5'd2, 5'd4, 5'd3, 1'b0); #1;
        n_chk++; if (st !== ST_LDB || bus.pc_wen !== 1'b0)
            $display("FAIL lu_bubble: got %h/%b want %h/0", st, bus.pc_wen, ST_LDB); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (bus.stall_cnt !== 16'd1) $display("FAIL lu_stallcnt: got %0d want 1", bus.stall_cnt); else n_pass++;
        n_chk++; if (st !== ST_EN || bus.pc_wen !== 1'b1)
            $display("FAIL lu_one_cycle: got %h/%b want %h/1", st, bus.pc_wen, ST_EN); else n_pass++;
        @(negedge clk); drive_idle(); bus.ex_rs = 5'd2; bus.ex_rt = 5'd4; #1;
        n_chk++; if (bus.fsel_a !== 2'd2) $display("FAIL lu_fwd_wb: got %0d want 2", bus.fsel_a); else n_pass++;
        n_chk++; if (bus.fsel_b !== 2'd0) $display("FAIL lu_fwd_none: got %0d want 0", bus.fsel_b); else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        decode(5'd1, 5'd1, 5'd5, 1'b0);
        @(negedge clk); decode(5'd1, 5'd1, 5'd5, 1'b0);
        @(negedge clk); drive_idle();
        @(negedge clk); bus.ex_rs = 5'd5; bus.ex_rt = 5'd5; #1;
        n_chk++; if (bus.fsel_a !== 2'd1) $display("FAIL fwd_nearest_a: got %0d want 1", bus.fsel_a); else n_pass++;
        n_chk++; if (bus.fsel_b !== 2'd1) $display("FAIL fwd_nearest_b: got %0d want 1", bus.fsel_b); else n_pass++;
        bus.ex_rs = 5'd0; bus.ex_rt = 5'd7; #1;
        n_chk++; if (bus.fsel_a !== 2'd0) $display("FAIL fwd_r0: got %0d want 0", bus.fsel_a); else n_pass++;
        n_chk++; if (bus.fsel_b !== 2'd0) $display("FAIL fwd_nomatch: got %0d want 0", bus.fsel_b); else n_pass++;
        @(negedge clk); bus.ex_rs = 5'd5; #1;
        n_chk++; if (bus.fsel_a !== 2'd2) $display("FAIL fwd_wb_only: got %0d want 2", bus.fsel_a); else n_pass++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.dREN = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (st !== ST_STALL || bus.pc_wen !== 1'b0)
                $display("FAIL mw_stall_%0d: got %h/%b want %h/0", i, st, bus.pc_wen, ST_STALL); else n_pass++;
            @(negedge clk);
        end
        bus.dhit = 1'b1; #1;
        n_chk++; if (bus.stall_cnt !== 16'd3) $display("FAIL mw_stallcnt: got %0d want 3", bus.stall_cnt); else n_pass++;
        n_chk++; if (st !== ST_EN) $display("FAIL mw_exit: got %h want %h", st, ST_EN); else n_pass++;
        @(negedge clk); bus.dREN = 1'b0; bus.dhit = 1'b0; #1;
        n_chk++; if (st !== ST_EN || bus.pc_wen !== 1'b1 || bus.stall_cnt !== 16'd3)
            $display("FAIL mw_after: got %h/%b/%0d want %h/1/3", st, bus.pc_wen, bus.stall_cnt, ST_EN); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        decode(5'd0, 5'd0, 5'd2, 1'b1);
        @(negedge clk); decode(5'd2, 5'd4, 5'd3, 1'b0); bus.branch_taken = 1'b1; #1;
        n_chk++; if (st !== ST_FLB || bus.pc_wen !== 1'b1)
            $display("FAIL fl_entry: got %h/%b want %h/1", st, bus.pc_wen, ST_FLB); else n_pass++;
        @(negedge clk); drive_idle(); bus.ihit = 1'b0; #1;
        n_chk++; if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd0)
            $display("FAIL fl_cnts: got %0d/%0d want 1/0", bus.flush_cnt, bus.stall_cnt); else n_pass++;
        n_chk++; if (bus.fd_state !== PIPE_NOP || bus.pc_wen !== 1'b0)
            $display("FAIL fl_wait: got %0d/%b want 0/0", bus.fd_state, bus.pc_wen); else n_pass++;
        @(negedge clk); bus.ihit = 1'b1;
        @(negedge clk); #1;
        n_chk++; if (st !== ST_EN || bus.pc_wen !== 1'b1)
            $display("FAIL fl_back_run: got %h/%b want %h/1", st, bus.pc_wen, ST_EN); else n_pass++;
        @(negedge clk); bus.jump = 1'b1; #1;
        n_chk++; if (st !== ST_FLB) $display("FAIL fl_jump: got %h want %h", st, ST_FLB); else n_pass++;
        @(negedge clk); bus.jump = 1'b0; #1;
        n_chk++; if (bus.flush_cnt !== 16'd2) $display("FAIL fl_cnt2: got %0d want 2", bus.flush_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [1:0] want_sat;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            decode(5'd0, 5'd0, 5'd2, 1'b1);
            @(negedge clk); decode(5'd2, 5'd0, 5'd3, 1'b0);
            @(negedge clk); drive_idle();
            @(negedge clk); #1;
            want_sat = (i >= 3) ? 2'd3 : 2'(i);
            n_chk++; if (bus2.stall_cnt !== want_sat)
                $display("FAIL sat_cnt_%0d: got %0d want %0d", i, bus2.stall_cnt, want_sat); else n_pass++;
        end
        n_chk++; if (bus.stall_cnt !== 16'd5) $display("FAIL sat_wide_cnt: got %0d want 5", bus.stall_cnt); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        drive_idle();
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
